mux32_fault_campaign_ctrl: RTL and testbench

- Sequencer that runs a stuck-at fault-injection campaign on the gate-level MUX32 netlist, whose fault-enable input is `f`.
- Generates pseudo-random data1/data2/select vectors from an LFSR and drives them into the netlist.
- Computes the golden mux result internally and compares it against the netlist output.
- Runs a clean pass (f=0) followed by a faulted pass (f=1) over the same vector sequence; reports detection status, first detecting vector and mismatch count.

---
 rtl/mux_fault_pkg.sv | 21 ++
 rtl/mux_vec_gen.sv | 45 ++++
 rtl/mux32_fault_campaign_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mux32_fault_campaign_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_fault_pkg.sv
// Shared constants and state encoding for the MUX32 fault-injection campaign controller.
package mux_fault_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [31:0] DEF_SEED    = 32'hACE1_2468;
  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] D2_SCRAMBLE = 32'h5555_5555;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_CLEAN_RUN,
    ST_DRAIN_C,
    ST_FAULT_RUN,
    ST_DRAIN_F,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mux_vec_gen.sv
// Galois LFSR plus mapping of its state onto registered data1/data2/select vectors.
module mux_vec_gen
  import mux_fault_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic             select
);

  localparam int unsigned HALF = WIDTH / 2;

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] src_next;

  // Vector source is the seed on a load, else the current LFSR state; advance it by one step.
  always_comb begin
    src      = load ? seed : lfsr_q;
    src_next = (src >> 1) ^ (src[0] ? WIDTH'(LFSR_TAPS) : '0);
  end

  // Present the source as a vector and move the LFSR on; hold everything otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= RST_SEED;
      data1  <= '0;
      data2  <= '0;
      select <= 1'b0;
    end else if (load || step) begin
      lfsr_q <= src_next;
      data1  <= src;
      data2  <= {src[HALF-1:0], src[WIDTH-1:HALF]} ^ WIDTH'(D2_SCRAMBLE);
      select <= src[0] ^ src[WIDTH-1];
    end
  end

endmodule

// File: rtl/mux32_fault_campaign_ctrl.sv
// Runs a clean pass then a faulted pass of LFSR vectors into the MUX32 netlist and scores mismatches.
module mux32_fault_campaign_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] DEF_SEED = 32'hACE1_2468
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      seed_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic [WIDTH-1:0] data1_o,
  output logic [WIDTH-1:0] data2_o,
  output logic             select_o,
  output logic             fault_o,
  input  logic [WIDTH-1:0] dut_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             clean_err_o,
  output logic             detected_o,
  output logic [CNT_W-1:0] first_det_idx_o,
  output logic [CNT_W-1:0] mismatch_cnt_o
);
  import mux_fault_pkg::*;

  state_e           state;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] idx_q;
  logic [31:0]      seed_q;

  logic             cmp_valid_q;
  logic             cmp_fault_q;
  logic             cmp_mis_q;
  logic [CNT_W-1:0] cmp_idx_q;

  logic             run_c;
  logic             last_vec_c;
  logic             clean_err_c;
  logic             vg_load_c;
  logic             vg_step_c;
  logic [WIDTH-1:0] golden_c;

  // Control decodes; clean_err_c folds in the mismatch still waiting in the compare stage.
  always_comb begin
    run_c       = (state == ST_CLEAN_RUN) || (state == ST_FAULT_RUN);
    last_vec_c  = (idx_q == n_q - CNT_W'(1));
    clean_err_c = clean_err_o | (cmp_valid_q & ~cmp_fault_q & cmp_mis_q);
    vg_load_c   = !abort_i && (((state == ST_SEED) && (n_q != '0)) ||
                               ((state == ST_DRAIN_C) && !clean_err_c));
    vg_step_c   = !abort_i && run_c && !last_vec_c;
    golden_c    = select_o ? data2_o : data1_o;
  end

  mux_vec_gen #(
    .WIDTH    (WIDTH),
    .RST_SEED (WIDTH'(DEF_SEED))
  ) u_vec_gen (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (vg_load_c),
    .step   (vg_step_c),
    .seed   (WIDTH'(seed_q)),
    .data1  (data1_o),
    .data2  (data2_o),
    .select (select_o)
  );

  // Campaign sequencer with registered busy/done/fault.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      fault_o <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      seed_q  <= DEF_SEED;
    end else begin
      done_o <= 1'b0;
      if ((state != ST_IDLE) && abort_i) begin
        state   <= ST_IDLE;
        busy_o  <= 1'b0;
        fault_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              n_q    <= num_vec_i;
              seed_q <= (seed_i == '0) ? DEF_SEED : seed_i;
              busy_o <= 1'b1;
              state  <= ST_SEED;
            end
          end
          ST_SEED: begin
            idx_q <= '0;
            if (n_q == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state <= ST_CLEAN_RUN;
            end
          end
          ST_CLEAN_RUN: begin
            if (last_vec_c) state <= ST_DRAIN_C;
            else            idx_q <= idx_q + CNT_W'(1);
          end
          ST_DRAIN_C: begin
            if (clean_err_c) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state   <= ST_FAULT_RUN;
              fault_o <= 1'b1;
              idx_q   <= '0;
            end
          end
          ST_FAULT_RUN: begin
            if (last_vec_c) state <= ST_DRAIN_F;
            else            idx_q <= idx_q + CNT_W'(1);
          end
          ST_DRAIN_F: begin
            state   <= ST_DONE;
            done_o  <= 1'b1;
            fault_o <= 1'b0;
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Capture the compare result of the vector currently on the netlist inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_valid_q <= 1'b0;
      cmp_fault_q <= 1'b0;
      cmp_mis_q   <= 1'b0;
      cmp_idx_q   <= '0;
    end else begin
      cmp_valid_q <= run_c && !abort_i;
      cmp_fault_q <= (state == ST_FAULT_RUN);
      cmp_mis_q   <= (dut_data_i != golden_c);
      cmp_idx_q   <= idx_q;
    end
  end

  // Accumulate compare results one cycle behind the vectors.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clean_err_o     <= 1'b0;
      detected_o      <= 1'b0;
      first_det_idx_o <= '0;
      mismatch_cnt_o  <= '0;
    end else if ((state == ST_IDLE) && start_i) begin
      clean_err_o     <= 1'b0;
      detected_o      <= 1'b0;
      first_det_idx_o <= '0;
      mismatch_cnt_o  <= '0;
    end else if (cmp_valid_q && cmp_mis_q) begin
      if (!cmp_fault_q) begin
        clean_err_o <= 1'b1;
      end else begin
        if (!detected_o) begin
          detected_o      <= 1'b1;
          first_det_idx_o <= cmp_idx_q;
        end
        if (mismatch_cnt_o != '1) mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux32_fault_campaign_ctrl.sv
// Directed bench for the MUX32 fault-campaign controller with a behavioural netlist model.
module tb_mux32_fault_campaign_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] DEF_SEED_TB = 32'hACE1_2468;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic             abort_i;
  logic [31:0]      seed_i;
  logic [CNT_W-1:0] num_vec_i;
  logic [WIDTH-1:0] data1_o, data2_o, dut_data;
  logic             select_o, fault_o, busy_o, done_o;
  logic             clean_err_o, detected_o;
  logic [CNT_W-1:0] first_det_idx_o, mismatch_cnt_o;

  // 0: fault-free, 1: all-ones when f=1, 2: always data1
  int mode;

  int total = 0;
  int bad   = 0;

  logic [31:0] tr_d1  [0:79];
  logic [31:0] tr_d2  [0:79];
  logic        tr_sel [0:79];
  logic        tr_f   [0:79];
  logic        tr_busy[0:79];
  int          done_cyc;
  int          done_pulses;
  bit          fault_seen;

  always #5 clk = ~clk;

  assign dut_data = (mode == 2) ? data1_o :
                    ((mode == 1) && fault_o) ? 32'hFFFF_FFFF :
                    (select_o ? data2_o : data1_o);

  mux32_fault_campaign_ctrl #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .DEF_SEED (DEF_SEED_TB)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .seed_i          (seed_i),
    .num_vec_i       (num_vec_i),
    .data1_o         (data1_o),
    .data2_o         (data2_o),
    .select_o        (select_o),
    .fault_o         (fault_o),
    .dut_data_i      (dut_data),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .clean_err_o     (clean_err_o),
    .detected_o      (detected_o),
    .first_det_idx_o (first_det_idx_o),
    .mismatch_cnt_o  (mismatch_cnt_o)
  );

  // Reference vector i of a pass started from seed s.
  function automatic void exp_vec(input logic [31:0] s, input int i,
                                  output logic [31:0] d1, output logic [31:0] d2,
                                  output logic sel);
    logic [31:0] l;
    l = (s == 32'h0) ? DEF_SEED_TB : s;
    for (int k = 0; k < i; k++) l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    d1  = l;
    d2  = {l[15:0], l[31:16]} ^ 32'h5555_5555;
    sel = l[0] ^ l[31];
  endfunction

  // Start a campaign at edge 0 and record per-cycle outputs; cycle c is the period after edge c-1.
  task automatic run(input logic [31:0] seed, input logic [CNT_W-1:0] n,
                     input int mode_v, input int start_pulse_cyc);
    int limit;
    mode      = mode_v;
    seed_i    = seed;
    num_vec_i = n;
    limit     = 2 * int'(n) + 8;
    if (limit > 79) limit = 79;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i     = 1'b0;
    seed_i      = 32'hDEAD_BEEF;
    num_vec_i   = CNT_W'(3);
    done_cyc    = -1;
    done_pulses = 0;
    fault_seen  = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      tr_d1[c]   = data1_o;
      tr_d2[c]   = data2_o;
      tr_sel[c]  = select_o;
      tr_f[c]    = fault_o;
      tr_busy[c] = busy_o;
      if (fault_o) fault_seen = 1'b1;
      if (done_o) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      start_i = (c == start_pulse_cyc);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; seed_i = '0; num_vec_i = '0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy_o, done_o, fault_o, select_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {busy_o, done_o, fault_o, select_o});
    end
    total++;
    if ({data1_o, data2_o} !== 64'h0) begin
      bad++; $display("FAIL reset_vec got=%h_%h want=0", data1_o, data2_o);
    end
    total++;
    if ({clean_err_o, detected_o, first_det_idx_o, mismatch_cnt_o} !== 34'h0) begin
      bad++; $display("FAIL reset_results got=%b %b %0d %0d want=0", clean_err_o, detected_o,
                      first_det_idx_o, mismatch_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_pass();
    logic [31:0] d1, d2;
    logic        sel;
    run(32'h1357_9BDF, CNT_W'(16), 0, 10);
    total++;
    if (done_cyc !== 36) begin bad++; $display("FAIL clean_done_cycle got=%0d want=36", done_cyc); end
    total++;
    if (done_pulses !== 1) begin bad++; $display("FAIL clean_done_pulses got=%0d want=1", done_pulses); end
    total++;
    if ({clean_err_o, detected_o, mismatch_cnt_o} !== 18'h0) begin
      bad++; $display("FAIL clean_results got=%b %b %0d want=0 0 0", clean_err_o, detected_o, mismatch_cnt_o);
    end
    total++;
    if ({tr_busy[1], tr_busy[36]} !== 2'b11) begin
      bad++; $display("FAIL clean_busy got=%b want=11", {tr_busy[1], tr_busy[36]});
    end
    for (int i = 0; i < 16; i++) begin
      exp_vec(32'h1357_9BDF, i, d1, d2, sel);
      total++;
      if ({tr_d1[2+i], tr_d2[2+i], tr_sel[2+i], tr_f[2+i]} !== {d1, d2, sel, 1'b0}) begin
        bad++; $display("FAIL clean_vec%0d got=%h %h %b f=%b want=%h %h %b f=0", i,
                        tr_d1[2+i], tr_d2[2+i], tr_sel[2+i], tr_f[2+i], d1, d2, sel);
      end
      total++;
      if ({tr_d1[19+i], tr_d2[19+i], tr_sel[19+i], tr_f[19+i]} !== {d1, d2, sel, 1'b1}) begin
        bad++; $display("FAIL fault_vec%0d got=%h %h %b f=%b want=%h %h %b f=1", i,
                        tr_d1[19+i], tr_d2[19+i], tr_sel[19+i], tr_f[19+i], d1, d2, sel);
      end
    end
    total++;
    if ({tr_f[35], tr_f[36]} !== 2'b10) begin
      bad++; $display("FAIL fault_drain_done got=%b want=10", {tr_f[35], tr_f[36]});
    end
  endtask

  task automatic test_fault_detect();
    run(32'h1234_5678, CNT_W'(16), 1, 0);
    total++;
    if (done_cyc !== 36) begin bad++; $display("FAIL detect_done_cycle got=%0d want=36", done_cyc); end
    total++;
    if ({clean_err_o, detected_o} !== 2'b01) begin
      bad++; $display("FAIL detect_flags got=%b want=01", {clean_err_o, detected_o});
    end
    total++;
    if (first_det_idx_o !== 16'd0) begin
      bad++; $display("FAIL detect_first_idx got=%0d want=0", first_det_idx_o);
    end
    total++;
    if (mismatch_cnt_o !== 16'd16) begin
      bad++; $display("FAIL detect_count got=%0d want=16", mismatch_cnt_o);
    end
  endtask

  task automatic test_zero_n();
    run(32'h0000_0001, CNT_W'(0), 1, 0);
    total++;
    if (done_cyc !== 2) begin bad++; $display("FAIL zero_n_done_cycle got=%0d want=2", done_cyc); end
    total++;
    if ({clean_err_o, detected_o, first_det_idx_o, mismatch_cnt_o} !== 34'h0) begin
      bad++; $display("FAIL zero_n_results got=%b %b %0d %0d want=0", clean_err_o, detected_o,
                      first_det_idx_o, mismatch_cnt_o);
    end
    total++;
    if (fault_seen !== 1'b0) begin bad++; $display("FAIL zero_n_fault got=1 want=0"); end
  endtask

  task automatic test_clean_err();
    run(32'hC0FF_EE11, CNT_W'(16), 2, 0);
    total++;
    if (done_cyc !== 19) begin bad++; $display("FAIL clean_err_done_cycle got=%0d want=19", done_cyc); end
    total++;
    if ({clean_err_o, detected_o, mismatch_cnt_o} !== {1'b1, 1'b0, 16'd0}) begin
      bad++; $display("FAIL clean_err_results got=%b %b %0d want=1 0 0", clean_err_o, detected_o, mismatch_cnt_o);
    end
    total++;
    if (fault_seen !== 1'b0) begin bad++; $display("FAIL clean_err_fault_seen got=1 want=0"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1 [0:7];
    logic [31:0] d1, d2;
    logic        sel;
    run(32'h89AB_CDEF, CNT_W'(8), 0, 0);
    for (int i = 0; i < 8; i++) s1[i] = tr_d1[2+i];
    run(32'h89AB_CDEF, CNT_W'(8), 0, 0);
    total++;
    if (done_cyc !== 20) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=20", done_cyc); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (tr_d1[2+i] !== s1[i]) begin
        bad++; $display("FAIL b2b_repeat%0d got=%h want=%h", i, tr_d1[2+i], s1[i]);
      end
    end
    run(32'h0, CNT_W'(8), 0, 0);
    for (int i = 0; i < 8; i++) begin
      exp_vec(DEF_SEED_TB, i, d1, d2, sel);
      total++;
      if ({tr_d1[2+i], tr_d2[2+i], tr_sel[2+i]} !== {d1, d2, sel}) begin
        bad++; $display("FAIL zero_seed_vec%0d got=%h %h %b want=%h %h %b", i,
                        tr_d1[2+i], tr_d2[2+i], tr_sel[2+i], d1, d2, sel);
      end
    end
  endtask

  task automatic test_abort();
    int done_seen;
    mode = 1; seed_i = 32'h0BAD_F00D; num_vec_i = CNT_W'(16);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c < 24; c++) begin @(posedge clk); #1; end
    total++;
    if ({busy_o, fault_o} !== 2'b11) begin
      bad++; $display("FAIL abort_pre got=%b want=11", {busy_o, fault_o});
    end
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    total++;
    if ({busy_o, fault_o, done_o} !== 3'b000) begin
      bad++; $display("FAIL abort_post got=%b want=000", {busy_o, fault_o, done_o});
    end
    total++;
    if (detected_o !== 1'b1) begin bad++; $display("FAIL abort_partial got=%b want=1", detected_o); end
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done_o || busy_o) done_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (done_seen !== 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", done_seen); end
  endtask

  task automatic test_reset_mid_run();
    mode = 0; seed_i = 32'h5A5A_1234; num_vec_i = CNT_W'(16);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({busy_o, done_o, fault_o, select_o, data1_o, data2_o} !== 68'h0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b %h %h want=0", {busy_o, done_o, fault_o, select_o},
                      data1_o, data2_o);
    end
    total++;
    if ({clean_err_o, detected_o, first_det_idx_o, mismatch_cnt_o} !== 34'h0) begin
      bad++; $display("FAIL rst_mid_results got=%b %b %0d %0d want=0", clean_err_o, detected_o,
                      first_det_idx_o, mismatch_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_fault_detect();
    test_zero_n();
    test_clean_err();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
